ifm_s2mm_axis: RTL

IFM_S2MM_AXIS -- requirements
Module: ifm_s2mm_axis

---
 rtl/ifm_s2mm_axis.sv | 66 ++++++
 1 files changed

// File: rtl/ifm_s2mm_axis.sv
// ifm_s2mm_axis: drains FWFT good/ctrl FIFOs into the DMA S2MM data and status AXI-Stream ports,
// alternating one data frame with its status frame, and flags malformed status frames.
module ifm_s2mm_axis (
   input  logic        s2mm_clk,
   input  logic        s2mm_resetn,
   input  logic [72:0] good_fifo_rdata,
   input  logic        good_fifo_empty,
   output logic        good_fifo_rden,
   input  logic [36:0] ctrl_fifo_rdata,
   input  logic        ctrl_fifo_empty,
   output logic        ctrl_fifo_rden,
   output logic [63:0] m_axis_s2mm_tdata,
   output logic [7:0]  m_axis_s2mm_tkeep,
   output logic        m_axis_s2mm_tlast,
   output logic        m_axis_s2mm_tvalid,
   input  logic        m_axis_s2mm_tready,
   output logic [31:0] m_axis_s2mm_sts_tdata,
   output logic [3:0]  m_axis_s2mm_sts_tkeep,
   output logic        m_axis_s2mm_sts_tlast,
   output logic        m_axis_s2mm_sts_tvalid,
   input  logic        m_axis_s2mm_sts_tready,
   output logic [15:0] frame_cnt,
   output logic        sts_len_err,
   output logic [3:0]  ifm_s2mm_dbg
);
   typedef enum logic [1:0] {S_IDLE = 2'h0, S_DATA = 2'h1, S_STS = 2'h2} state_t;
   state_t     state;
   logic [5:0] sts_cnt;
   logic       d_space, s_space;
   assign d_space        = ~m_axis_s2mm_tvalid | m_axis_s2mm_tready;
   assign s_space        = ~m_axis_s2mm_sts_tvalid | m_axis_s2mm_sts_tready;
   assign good_fifo_rden = s2mm_resetn & (state == S_DATA) & ~good_fifo_empty & d_space;
   assign ctrl_fifo_rden = s2mm_resetn & (state == S_STS) & ~ctrl_fifo_empty & s_space;
   assign ifm_s2mm_dbg   = {m_axis_s2mm_sts_tvalid, m_axis_s2mm_tvalid, state};
   always_ff @(posedge s2mm_clk or negedge s2mm_resetn)
      if (!s2mm_resetn) begin
         state                  <= S_IDLE;
         m_axis_s2mm_tvalid     <= 1'b0;
         m_axis_s2mm_sts_tvalid <= 1'b0;
         frame_cnt              <= 16'd0;
         sts_len_err            <= 1'b0;
         sts_cnt                <= 6'd0;
      end else begin
         case (state)
            S_IDLE:  if (!good_fifo_empty) state <= S_DATA;
            S_DATA:  if (good_fifo_rden && good_fifo_rdata[72]) state <= S_STS;
            S_STS:   if (ctrl_fifo_rden && ctrl_fifo_rdata[36]) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         m_axis_s2mm_tvalid     <= good_fifo_rden | (m_axis_s2mm_tvalid & ~m_axis_s2mm_tready);
         m_axis_s2mm_sts_tvalid <= ctrl_fifo_rden | (m_axis_s2mm_sts_tvalid & ~m_axis_s2mm_sts_tready);
         sts_cnt <= (state == S_IDLE) ? 6'd0 :
                    (ctrl_fifo_rden && sts_cnt != 6'd63) ? sts_cnt + 6'd1 : sts_cnt;
         // a well-formed status frame is exactly six words, last on the sixth
         if (ctrl_fifo_rden && (ctrl_fifo_rdata[36] ? sts_cnt != 6'd5 : sts_cnt >= 6'd6))
            sts_len_err <= 1'b1;
         if (m_axis_s2mm_sts_tvalid && m_axis_s2mm_sts_tready && m_axis_s2mm_sts_tlast)
            frame_cnt <= frame_cnt + 16'd1;
      end
   always_ff @(posedge s2mm_clk) begin
      if (good_fifo_rden)
         {m_axis_s2mm_tlast, m_axis_s2mm_tkeep, m_axis_s2mm_tdata} <= good_fifo_rdata;
      if (ctrl_fifo_rden)
         {m_axis_s2mm_sts_tlast, m_axis_s2mm_sts_tkeep, m_axis_s2mm_sts_tdata} <= ctrl_fifo_rdata;
   end
endmodule
